// File: rtl/sd_spi_responder_pkg.sv
// Shared constants and types for the SPI-mode SD card responder.
// Holds command indices, tokens, R1 bit positions and FSM state encodings.
`timescale 1ns/1ps
package sd_spi_responder_pkg;

    localparam logic [5:0] CMD_GO_IDLE       = 6'd0;
    localparam logic [5:0] CMD_SEND_IF_COND  = 6'd8;
    localparam logic [5:0] CMD_READ_BLOCK    = 6'd17;
    localparam logic [5:0] CMD_WRITE_BLOCK   = 6'd24;
    localparam logic [5:0] ACMD_SEND_OP_COND = 6'd41;
    localparam logic [5:0] CMD_APP_CMD       = 6'd55;
    localparam logic [5:0] CMD_READ_OCR      = 6'd58;

    localparam logic [7:0] TOKEN_START    = 8'hFE;
    localparam logic [7:0] DRESP_ACCEPTED = 8'h05;
    localparam logic [7:0] IDLE_BYTE      = 8'hFF;
    localparam logic [7:0] BUSY_BYTE      = 8'h00;
    localparam logic [7:0] CMD8_VOLTAGE   = 8'h01;
    localparam logic [31:0] OCR_VALUE     = 32'hC0FF8000;

    localparam int R1_IN_IDLE  = 0;
    localparam int R1_ILLEGAL  = 2;
    localparam int R1_ADDR_ERR = 6;

    typedef enum logic [3:0] {
        RX_CMD, NCR, TX_R1, TX_R7, RD_GAP, TX_TOKEN, TX_DATA, TX_CRC,
        WR_HUNT, RX_DATA, RX_CRC, TX_DRESP, TX_BUSY
    } state_t;

    // What follows R1 once it has been sent.
    typedef enum logic [1:0] {RESP_R1, RESP_R7, RESP_READ, RESP_WRITE} resp_t;

    function automatic logic [7:0] make_r1(input logic addr_err, input logic illegal,
                                           input logic in_idle);
        logic [7:0] r1;
        r1 = 8'h00;
        r1[R1_ADDR_ERR] = addr_err;
        r1[R1_ILLEGAL]  = illegal;
        r1[R1_IN_IDLE]  = in_idle;
        return r1;
    endfunction

endpackage

// File: rtl/sd_block_ram.sv
// Byte-wide single-port block storage with synchronous write and registered read.
`timescale 1ns/1ps
module sd_block_ram
    import sd_spi_responder_pkg::*;
#(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           wdata,
    output logic [7:0]           rdata
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sd_spi_responder.sv
// SPI-mode SD card emulator: decodes command frames from an oversampled SPI bus
// and answers init, OCR, single-block read and single-block write commands.
`timescale 1ns/1ps
module sd_spi_responder
    import sd_spi_responder_pkg::*;
#(
    parameter int BLOCK_ADDR_BITS = 3,
    parameter int NCR_BYTES       = 1,
    parameter int INIT_POLLS      = 2,
    parameter int BUSY_BYTES      = 4
) (
    input  logic CLK,
    input  logic RESET_n,
    input  logic SD_CLK,
    input  logic SD_CS,
    input  logic SD_DI,
    output logic SD_DO,
    output logic CARD_READY,
    output logic ACCESS_ACTIVE
);

    localparam int RAM_BITS = BLOCK_ADDR_BITS + 9;

    // Synchronizer bit order: {SD_CLK, SD_CS, SD_DI}; idle bus levels on reset.
    logic [2:0] sync_meta, sync_out;
    logic       sclk_prev;
    logic       sclk_rise, sclk_fall, cs_s, di_s;

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            sync_meta <= 3'b011;
            sync_out  <= 3'b011;
            sclk_prev <= 1'b0;
        end else begin
            sync_meta <= {SD_CLK, SD_CS, SD_DI};
            sync_out  <= sync_meta;
            sclk_prev <= sync_out[2];
        end
    end

    assign sclk_rise = sync_out[2] & ~sclk_prev;
    assign sclk_fall = ~sync_out[2] & sclk_prev;
    assign cs_s      = sync_out[1];
    assign di_s      = sync_out[0];

    state_t                     state_reg, state_next;
    resp_t                      resp_reg, resp_next, resp_kind;
    logic [2:0]                 bit_cnt_reg, bit_cnt_next;
    logic [8:0]                 byte_cnt_reg, byte_cnt_next;
    logic                       in_frame_reg, in_frame_next;
    logic [39:0]                cmd_reg, cmd_next;
    logic [6:0]                 rx_shift_reg, rx_shift_next;
    logic [7:0]                 tx_shift_reg, tx_shift_next;
    logic                       do_reg, do_next;
    logic [7:0]                 r1_reg, r1_next, r1_value;
    logic [31:0]                r7_reg, r7_next, r7_value;
    logic [BLOCK_ADDR_BITS-1:0] block_reg, block_next;
    logic                       ready_reg, ready_next;
    logic [7:0]                 poll_cnt_reg, poll_cnt_next;
    logic                       app_reg, app_next;
    logic                       byte_done, addr_err, illegal, in_idle, ram_we;
    logic [7:0]                 rx_byte, ram_rdata;
    logic [5:0]                 cmd_idx;
    logic [31:0]                cmd_arg;

    assign rx_byte = {rx_shift_reg, di_s};
    assign cmd_idx = cmd_reg[37:32];
    assign cmd_arg = cmd_reg[31:0];

    sd_block_ram #(.ADDR_BITS(RAM_BITS)) u_ram (
        .clk   (CLK),
        .we    (ram_we),
        .addr  ({block_reg, byte_cnt_reg}),
        .wdata (rx_byte),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg    <= RX_CMD;
            resp_reg     <= RESP_R1;
            bit_cnt_reg  <= '0;
            byte_cnt_reg <= '0;
            in_frame_reg <= 1'b0;
            cmd_reg      <= '0;
            rx_shift_reg <= '0;
            tx_shift_reg <= IDLE_BYTE;
            do_reg       <= 1'b1;
            r1_reg       <= '0;
            r7_reg       <= '0;
            block_reg    <= '0;
            ready_reg    <= 1'b0;
            poll_cnt_reg <= '0;
            app_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            resp_reg     <= resp_next;
            bit_cnt_reg  <= bit_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            in_frame_reg <= in_frame_next;
            cmd_reg      <= cmd_next;
            rx_shift_reg <= rx_shift_next;
            tx_shift_reg <= tx_shift_next;
            do_reg       <= do_next;
            r1_reg       <= r1_next;
            r7_reg       <= r7_next;
            block_reg    <= block_next;
            ready_reg    <= ready_next;
            poll_cnt_reg <= poll_cnt_next;
            app_reg      <= app_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        resp_next     = resp_reg;
        bit_cnt_next  = bit_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        in_frame_next = in_frame_reg;
        cmd_next      = cmd_reg;
        rx_shift_next = rx_shift_reg;
        tx_shift_next = tx_shift_reg;
        do_next       = do_reg;
        r1_next       = r1_reg;
        r7_next       = r7_reg;
        block_next    = block_reg;
        ready_next    = ready_reg;
        poll_cnt_next = poll_cnt_reg;
        app_next      = app_reg;
        byte_done     = 1'b0;
        addr_err      = 1'b0;
        illegal       = 1'b0;
        in_idle       = ~ready_reg;
        resp_kind     = RESP_R1;
        r7_value      = r7_reg;
        r1_value      = r1_reg;
        ram_we        = 1'b0;

        if (cs_s) begin
            state_next    = RX_CMD;
            bit_cnt_next  = '0;
            byte_cnt_next = '0;
            in_frame_next = 1'b0;
            app_next      = 1'b0;
            tx_shift_next = IDLE_BYTE;
            do_next       = 1'b1;
        end else begin
            if (sclk_fall) begin
                do_next       = tx_shift_reg[7];
                tx_shift_next = {tx_shift_reg[6:0], 1'b1};
            end
            // Idle 1s between frames do not advance the bit counter.
            if (sclk_rise && (state_reg != RX_CMD || in_frame_reg || !di_s)) begin
                rx_shift_next = rx_byte[6:0];
                bit_cnt_next  = bit_cnt_reg + 3'd1;
                byte_done     = (bit_cnt_reg == 3'd7);
                if (state_reg == RX_CMD) begin
                    in_frame_next = 1'b1;
                    if (byte_cnt_reg < 9'd5) begin
                        cmd_next = {cmd_reg[38:0], di_s};
                    end
                end
            end

            if (byte_done) begin
                case (state_reg)
                    RX_CMD: begin
                        if (byte_cnt_reg != 9'd5) begin
                            byte_cnt_next = byte_cnt_reg + 9'd1;
                        end else begin
                            byte_cnt_next = '0;
                            in_frame_next = 1'b0;
                            // The CRC byte only contributes its end bit, sampled now.
                            if (!cmd_reg[39] && cmd_reg[38] && di_s) begin
                                app_next = 1'b0;
                                if (app_reg && cmd_idx == ACMD_SEND_OP_COND) begin
                                    if (poll_cnt_reg < 8'(INIT_POLLS)) begin
                                        poll_cnt_next = poll_cnt_reg + 8'd1;
                                        in_idle       = 1'b1;
                                    end else begin
                                        ready_next = 1'b1;
                                        in_idle    = 1'b0;
                                    end
                                end else if (app_reg && cmd_idx != CMD_APP_CMD) begin
                                    illegal = 1'b1;
                                end else begin
                                    case (cmd_idx)
                                        CMD_GO_IDLE: begin
                                            ready_next    = 1'b0;
                                            poll_cnt_next = '0;
                                            in_idle       = 1'b1;
                                        end
                                        CMD_SEND_IF_COND: begin
                                            resp_kind = RESP_R7;
                                            r7_value  = {16'h0000, CMD8_VOLTAGE, cmd_arg[7:0]};
                                        end
                                        CMD_APP_CMD: app_next = 1'b1;
                                        CMD_READ_OCR: begin
                                            resp_kind = RESP_R7;
                                            r7_value  = OCR_VALUE;
                                        end
                                        CMD_READ_BLOCK, CMD_WRITE_BLOCK: begin
                                            illegal  = ~ready_reg;
                                            addr_err = |(cmd_arg >> BLOCK_ADDR_BITS);
                                            if (!illegal && !addr_err) begin
                                                resp_kind  = (cmd_idx == CMD_READ_BLOCK) ? RESP_READ
                                                                                         : RESP_WRITE;
                                                block_next = cmd_arg[BLOCK_ADDR_BITS-1:0];
                                            end
                                        end
                                        default: illegal = 1'b1;
                                    endcase
                                end
                                r1_value  = make_r1(addr_err, illegal, in_idle);
                                r1_next   = r1_value;
                                r7_next   = r7_value;
                                resp_next = resp_kind;
                                if (NCR_BYTES > 0) begin
                                    state_next    = NCR;
                                    tx_shift_next = IDLE_BYTE;
                                end else begin
                                    state_next    = TX_R1;
                                    tx_shift_next = r1_value;
                                end
                            end
                        end
                    end
                    NCR: begin
                        if (byte_cnt_reg == 9'(NCR_BYTES - 1)) begin
                            state_next    = TX_R1;
                            tx_shift_next = r1_reg;
                            byte_cnt_next = '0;
                        end else begin
                            tx_shift_next = IDLE_BYTE;
                            byte_cnt_next = byte_cnt_reg + 9'd1;
                        end
                    end
                    TX_R1: begin
                        byte_cnt_next = '0;
                        tx_shift_next = IDLE_BYTE;
                        case (resp_reg)
                            RESP_R7: begin
                                state_next    = TX_R7;
                                tx_shift_next = r7_reg[31:24];
                                r7_next       = {r7_reg[23:0], 8'h00};
                            end
                            RESP_READ:  state_next = RD_GAP;
                            RESP_WRITE: state_next = WR_HUNT;
                            default:    state_next = RX_CMD;
                        endcase
                    end
                    TX_R7: begin
                        if (byte_cnt_reg == 9'd3) begin
                            state_next    = RX_CMD;
                            tx_shift_next = IDLE_BYTE;
                            byte_cnt_next = '0;
                        end else begin
                            tx_shift_next = r7_reg[31:24];
                            r7_next       = {r7_reg[23:0], 8'h00};
                            byte_cnt_next = byte_cnt_reg + 9'd1;
                        end
                    end
                    RD_GAP: begin
                        state_next    = TX_TOKEN;
                        tx_shift_next = TOKEN_START;
                        byte_cnt_next = '0;
                    end
                    TX_TOKEN: begin
                        state_next    = TX_DATA;
                        tx_shift_next = ram_rdata;
                        byte_cnt_next = 9'd1;
                    end
                    TX_DATA: begin
                        // byte_cnt points at the prefetch address; it wraps to 0 after byte 511.
                        if (byte_cnt_reg == 9'd0) begin
                            state_next    = TX_CRC;
                            tx_shift_next = IDLE_BYTE;
                        end else begin
                            tx_shift_next = ram_rdata;
                            byte_cnt_next = byte_cnt_reg + 9'd1;
                        end
                    end
                    TX_CRC: begin
                        tx_shift_next = IDLE_BYTE;
                        if (byte_cnt_reg == 9'd1) begin
                            state_next    = RX_CMD;
                            byte_cnt_next = '0;
                        end else begin
                            byte_cnt_next = byte_cnt_reg + 9'd1;
                        end
                    end
                    WR_HUNT: begin
                        tx_shift_next = IDLE_BYTE;
                        if (rx_byte == TOKEN_START) begin
                            state_next    = RX_DATA;
                            byte_cnt_next = '0;
                        end else if (rx_byte != IDLE_BYTE) begin
                            state_next = RX_CMD;
                        end
                    end
                    RX_DATA: begin
                        ram_we        = 1'b1;
                        tx_shift_next = IDLE_BYTE;
                        byte_cnt_next = byte_cnt_reg + 9'd1;
                        if (byte_cnt_reg == 9'd511) begin
                            state_next = RX_CRC;
                        end
                    end
                    RX_CRC: begin
                        if (byte_cnt_reg == 9'd1) begin
                            state_next    = TX_DRESP;
                            tx_shift_next = DRESP_ACCEPTED;
                            byte_cnt_next = '0;
                        end else begin
                            tx_shift_next = IDLE_BYTE;
                            byte_cnt_next = byte_cnt_reg + 9'd1;
                        end
                    end
                    TX_DRESP: begin
                        byte_cnt_next = '0;
                        if (BUSY_BYTES > 0) begin
                            state_next    = TX_BUSY;
                            tx_shift_next = BUSY_BYTE;
                        end else begin
                            state_next    = RX_CMD;
                            tx_shift_next = IDLE_BYTE;
                        end
                    end
                    TX_BUSY: begin
                        if (byte_cnt_reg == 9'(BUSY_BYTES - 1)) begin
                            state_next    = RX_CMD;
                            tx_shift_next = IDLE_BYTE;
                            byte_cnt_next = '0;
                        end else begin
                            tx_shift_next = BUSY_BYTE;
                            byte_cnt_next = byte_cnt_reg + 9'd1;
                        end
                    end
                    default: begin
                        state_next    = RX_CMD;
                        tx_shift_next = IDLE_BYTE;
                        byte_cnt_next = '0;
                    end
                endcase
            end
        end
    end

    assign SD_DO         = do_reg;
    assign CARD_READY    = ready_reg;
    assign ACCESS_ACTIVE = (state_reg inside {RD_GAP, TX_TOKEN, TX_DATA, TX_CRC,
                                              WR_HUNT, RX_DATA, RX_CRC, TX_DRESP, TX_BUSY});

endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 SHALL have parameter BLOCK_ADDR_BITS, default 3, meaning number of 512-byte blocks is 2^BLOCK_ADDR_BITS.
REQ-002 SHALL have parameter NCR_BYTES, default 1, meaning 0xFF bytes sent before every R1.
REQ-003 SHALL have parameter INIT_POLLS, default 2, meaning ACMD41 calls answered 0x01 before the card reports ready.
REQ-004 SHALL have parameter BUSY_BYTES, default 4, meaning 0x00 bytes sent after a write data-response.
REQ-005 SHALL have port CLK, input, 1 bit, system clock at 100 MHz; one clock; all logic in this domain.
REQ-006 SHALL have port RESET_n, input, 1 bit, asynchronous active-low reset.
REQ-007 SHALL have port SD_CLK, input, 1 bit, SPI clock from the SD host; SD_CLK high and low phases each >= 3 CLK periods.
REQ-008 SHALL have port SD_CS, input, 1 bit, active-low chip select.
REQ-009 SHALL have port SD_DI, input, 1 bit, host-to-card data (MOSI).
REQ-010 SHALL have port SD_DO, output, 1 bit, card-to-host data (MISO).
REQ-011 SHALL have port CARD_READY, output, 1 bit, high after a successful ACMD41 init.
REQ-012 SHALL have port ACCESS_ACTIVE, output, 1 bit, high during any CMD17/CMD24 data phase.

Function
REQ-013 SHALL synchronize SD_CLK, SD_CS and SD_DI through 2 flops each and edge-detect SD_CLK in CLK: sample DI on rising edge, update DO on falling edge (SPI mode 0, MSB first).
REQ-014 SHALL, in RX_CMD, begin a frame on the first sampled 0, collect 48 bits, and accept it only if bit47=0, bit46=1, bit0=1; CRC is not checked; malformed frames are dropped silently.
REQ-015 SHALL answer each accepted frame with NCR_BYTES of 0xFF then R1, byte-aligned to the frame end.
REQ-016 SHALL use R1 = {0, addr_err, 0, 0, 0, illegal, 0, in_idle}, with in_idle = !CARD_READY.
REQ-017 SHALL handle CMD0 by clearing CARD_READY and the poll count and responding 0x01.
REQ-018 SHALL handle CMD8 with R1 then 4 bytes {0x00, 0x00, 0x01, arg[7:0]}.
REQ-019 SHALL handle CMD55 with R1 and set the app flag for the next frame only.
REQ-020 SHALL handle ACMD41 by responding 0x01 for the first INIT_POLLS calls and 0x00 afterwards, setting CARD_READY when 0x00 is sent.
REQ-021 SHALL handle CMD58 with R1 then 0xC0FF8000.
REQ-022 SHALL treat CMD17 (read) and CMD24 (write) as block-addressed; arg >= 2^BLOCK_ADDR_BITS sets addr_err; either command while not ready sets illegal; on any error, send R1 only.
REQ-023 SHALL answer any other index (or ACMD other than 41) with illegal set.
REQ-024 SHALL, for a good CMD17, send R1=0x00, 1 gap byte 0xFF, token 0xFE, 512 data bytes (offset 0 first), 2 CRC bytes 0xFF, then return to RX_CMD.
REQ-025 SHALL, for a good CMD24, send R1=0x00, skip whole 0xFF bytes until token 0xFE, store 512 bytes, discard 2 CRC bytes, send data-response 0x05, send BUSY_BYTES of 0x00, then return to RX_CMD; a non-0xFF, non-0xFE byte in the token hunt aborts the write to RX_CMD without storing.
REQ-026 SHALL use FSM states RX_CMD, NCR, TX_R1, TX_R7, RD_GAP, TX_TOKEN, TX_DATA, TX_CRC, WR_HUNT, RX_DATA, RX_CRC, TX_DRESP, TX_BUSY.
REQ-027 SHALL hold SD_DO=1 whenever it is not transmitting and whenever SD_CS=1.
REQ-028 SHALL, on SD_CS rising mid-operation, abort to RX_CMD, clear bit/byte counters and the app flag, keep RAM contents already written, and keep CARD_READY unchanged.
REQ-029 SHALL fetch the next read byte from RAM (1-cycle latency) immediately after the current byte is loaded, so it is ready before the next byte boundary.
REQ-030 SHALL use a 9-bit byte counter that wraps at 511 to end the data phase, with RAM address {block, counter}.

Reset
REQ-031 SHALL, while RESET_n=0, force SD_DO=1, CARD_READY=0, ACCESS_ACTIVE=0, FSM=RX_CMD, all counters and flags to 0; RAM is not cleared.

Structure
REQ-032 SHALL place command indices (0, 8, 17, 24, 41, 55, 58), tokens (0xFE, 0x05) and R1 bit positions in the shared header.
REQ-033 SHALL use one sub-module, sd_block_ram: byte-wide, single-port, synchronous read/write.

Verification
REQ-034 SHALL pass: CMD0 (40 00000000 95) -> after 1 byte of 0xFF, R1=0x01.
REQ-035 SHALL pass: CMD55 + ACMD41 sent three times -> R1 sequence 0x01, 0x01, 0x00 with CARD_READY rising on the third.
REQ-036 SHALL pass: with the card ready, CMD24 arg=2, token 0xFE, data bytes i%256 -> 0x05 then 4 bytes of 0x00; a following CMD17 arg=2 returns 0xFE + the identical 512 bytes + 0xFFFF.
REQ-037 SHALL pass: CMD17 arg=8 -> R1=0x40; CMD17 before init -> R1=0x05, no token.
REQ-038 SHALL pass: SD_CS raised after data byte 100 of CMD17 -> SD_DO=1, next CMD0 answered 0x01 normally.
REQ-039 SHALL pass: RESET_n pulsed low while in TX_DATA -> SD_DO=1 and CARD_READY=0 within the same cycle.
